// File: rtl/mcc_pkg.sv
// mcc_pkg -- shared definitions for the multicycle MIPS control unit.
//   * 4-bit state encodings (S_*)
//   * the six opcodes the FSM decodes (OP_*)
//   * alu_op / alu_src_b / pc_source field values
//   * ctrl_word_t: the ungated per-state control word from mcc_out_decode
package mcc_pkg;

   localparam logic [3:0] S_IF   = 4'd0;
   localparam logic [3:0] S_ID   = 4'd1;
   localparam logic [3:0] S_MADR = 4'd2;
   localparam logic [3:0] S_MRD  = 4'd3;
   localparam logic [3:0] S_MWB  = 4'd4;
   localparam logic [3:0] S_MWR  = 4'd5;
   localparam logic [3:0] S_REX  = 4'd6;
   localparam logic [3:0] S_RWB  = 4'd7;
   localparam logic [3:0] S_BEQ  = 4'd8;
   localparam logic [3:0] S_JMP  = 4'd9;
   localparam logic [3:0] S_AEX  = 4'd10;
   localparam logic [3:0] S_AWB  = 4'd11;
   localparam logic [3:0] S_HALT = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_BRANCH = 2'b11;

   localparam logic [1:0] PC_SRC_ALU  = 2'b00;
   localparam logic [1:0] PC_SRC_OUT  = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP = 2'b10;

   // Raw control word before step gating; pc_write/pc_write_cond are
   // folded into pc_en by the top level.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_word_t;

endpackage

// File: rtl/mcc_out_decode.sv
// mcc_out_decode -- purely combinational state-to-control-word table.
// Ports:
//   state : current FSM state (4 bits)
//   ctrl  : ungated control word for that state; all fields 0 unless set
module mcc_out_decode
   import mcc_pkg::*;
(
   input  logic [3:0] state,
   output ctrl_word_t ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.pc_source = PC_SRC_ALU;
            ctrl.pc_write  = 1'b1;
         end
         S_ID: begin
            // Speculatively compute the branch target while decoding
            ctrl.alu_src_b = SRC_B_BRANCH;
         end
         S_MADR, S_AEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRC_B_IMM;
         end
         S_MRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_REX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_OP_SUB;
            ctrl.pc_source     = PC_SRC_OUT;
            ctrl.pc_write_cond = 1'b1;
         end
         S_JMP: begin
            ctrl.pc_source = PC_SRC_JUMP;
            ctrl.pc_write  = 1'b1;
         end
         S_AWB: begin
            ctrl.reg_write = 1'b1;
         end
         default: ctrl = '0;   // HALT and unused encodings drive nothing
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control -- Moore-style control FSM for a multicycle MIPS core.
// Ports:
//   clk, rst_n        : clock; asynchronous active-low reset (to IF, count 0)
//   step              : one-cycle advance enable from the clock divider
//   opcode            : IR[31:26], stable from ID onward
//   zero              : ALU zero flag, used only for the beq PC write
//   pc_en ... alu_src_a, alu_src_b, alu_op, pc_source : datapath controls
//   state             : current state encoding
//   halted            : high only in HALT
//   instr_count       : number of IF steps taken (wraps at 16 bits)
module multicycle_control
   import mcc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic [5:0]  opcode,
   input  logic        zero,
   output logic        pc_en,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic        halted,
   output logic [15:0] instr_count
);

   logic [3:0]  state_reg, state_next;
   logic [15:0] instr_count_reg;
   ctrl_word_t  ctrl;

   always_comb begin
      state_next = S_HALT;
      case (state_reg)
         S_IF:   state_next = S_ID;
         S_ID: begin
            case (opcode)
               OP_RTYPE:     state_next = S_REX;
               OP_LW, OP_SW: state_next = S_MADR;
               OP_BEQ:       state_next = S_BEQ;
               OP_J:         state_next = S_JMP;
               OP_ADDI:      state_next = S_AEX;
               default:      state_next = S_HALT;
            endcase
         end
         // Only lw and sw reach MADR, and opcode is held, so sw is the only
         // case that needs distinguishing.
         S_MADR: state_next = (opcode == OP_SW) ? S_MWR : S_MRD;
         S_MRD:  state_next = S_MWB;
         S_REX:  state_next = S_RWB;
         S_AEX:  state_next = S_AWB;
         S_MWB, S_MWR, S_RWB, S_BEQ, S_JMP, S_AWB: state_next = S_IF;
         default: state_next = S_HALT;   // HALT stays; 12-14 fall into HALT
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IF;
         instr_count_reg <= 16'd0;
      end else if (step) begin
         state_reg <= state_next;
         // Counting on IF means HALT never advances the count.
         if (state_reg == S_IF)
            instr_count_reg <= instr_count_reg + 16'd1;
      end
   end

   mcc_out_decode u_out_decode (
      .state (state_reg),
      .ctrl  (ctrl)
   );

   // Write strobes are qualified by step so each fires once per state visit
   // even when the divider holds a state for many clk cycles.
   assign pc_en      = step & (ctrl.pc_write | (ctrl.pc_write_cond & zero));
   assign ir_write   = step & ctrl.ir_write;
   assign mem_write  = step & ctrl.mem_write;
   assign reg_write  = step & ctrl.reg_write;

   assign iord        = ctrl.iord;
   assign mem_read    = ctrl.mem_read;
   assign mem_to_reg  = ctrl.mem_to_reg;
   assign reg_dst     = ctrl.reg_dst;
   assign alu_src_a   = ctrl.alu_src_a;
   assign alu_src_b   = ctrl.alu_src_b;
   assign alu_op      = ctrl.alu_op;
   assign pc_source   = ctrl.pc_source;
   assign state       = state_reg;
   assign halted      = (state_reg == S_HALT);
   assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control -- table-driven self-checking bench for
// multicycle_control, plus hand-written multi-cycle sequences.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        step;
   logic [5:0]  opcode;
   logic        zero;
   logic        pc_en, iord, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic        halted;
   logic [15:0] instr_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .step        (step),
      .opcode      (opcode),
      .zero        (zero),
      .pc_en       (pc_en),
      .iord        (iord),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .mem_to_reg  (mem_to_reg),
      .reg_dst     (reg_dst),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .pc_source   (pc_source),
      .state       (state),
      .halted      (halted),
      .instr_count (instr_count)
   );

   // Observed output word:
   // {pc_en,iord,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,
   //  alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0],halted}
   logic [15:0] obs_word;
   assign obs_word = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
                      reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, halted};

   // Hand-computed words for each state with step=1
   localparam logic [15:0] W_IF    = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [15:0] W_ID    = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [15:0] W_MADR  = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [15:0] W_MRD   = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [15:0] W_MWB   = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [15:0] W_MWR   = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [15:0] W_REX   = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [15:0] W_RWB   = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [15:0] W_BEQ_T = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [15:0] W_BEQ_N = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [15:0] W_JMP   = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;
   localparam logic [15:0] W_AEX   = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [15:0] W_AWB   = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
   localparam logic [15:0] W_HALT  = 16'b0_0_0_0_0_0_0_0_0_00_00_00_1;

   // With step=0 the strobes pc_en, mem_write, ir_write, reg_write drop
   function automatic logic [15:0] gate(input logic [15:0] w, input logic s);
      return s ? w : (w & 16'h66FF);
   endfunction

   typedef struct {
      logic [5:0]  opcode;
      logic        zero;
      logic        step;
      logic [3:0]  exp_state;
      logic [15:0] exp_word;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [5:0] op, input logic z, input logic s,
                      input logic [3:0] st, input logic [15:0] w,
                      input logic [15:0] cnt);
      vec_t v;
      v.opcode = op; v.zero = z; v.step = s;
      v.exp_state = st; v.exp_word = w; v.exp_count = cnt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; step = 1'b0; zero = 1'b0; opcode = 6'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [3:0] seq_sw [4];
   int         mw_cycles;

   initial begin
      // Reset state, checked with step both high and low
      rst_n = 1'b0; step = 1'b1; zero = 1'b0; opcode = 6'd0;
      #1;
      check("reset_state", 16'(state), 16'd0);
      check("reset_word_step1", obs_word, W_IF);
      check("reset_count", instr_count, 16'd0);
      step = 1'b0;
      #1;
      check("reset_word_step0", obs_word, gate(W_IF, 1'b0));
      $display("reset: state=%0d word=%h count=%0d", state, obs_word, instr_count);

      // Instruction stream, one step per vector
      add(6'h23, 0, 1, 4'd0,  W_IF,   16'd0);   // lw
      add(6'h23, 0, 1, 4'd1,  W_ID,   16'd1);
      add(6'h23, 0, 1, 4'd2,  W_MADR, 16'd1);
      add(6'h23, 0, 1, 4'd3,  W_MRD,  16'd1);
      add(6'h23, 0, 1, 4'd4,  W_MWB,  16'd1);
      add(6'h2B, 0, 1, 4'd0,  W_IF,   16'd1);   // sw
      add(6'h2B, 0, 1, 4'd1,  W_ID,   16'd2);
      add(6'h2B, 0, 1, 4'd2,  W_MADR, 16'd2);
      add(6'h2B, 0, 1, 4'd5,  W_MWR,  16'd2);
      add(6'h00, 0, 1, 4'd0,  W_IF,   16'd2);   // R-type
      add(6'h00, 0, 1, 4'd1,  W_ID,   16'd3);
      add(6'h00, 0, 1, 4'd6,  W_REX,  16'd3);
      add(6'h00, 0, 1, 4'd7,  W_RWB,  16'd3);
      add(6'h08, 0, 1, 4'd0,  W_IF,   16'd3);   // addi
      add(6'h08, 0, 1, 4'd1,  W_ID,   16'd4);
      add(6'h08, 0, 1, 4'd10, W_AEX,  16'd4);
      add(6'h08, 0, 1, 4'd11, W_AWB,  16'd4);
      add(6'h04, 1, 1, 4'd0,  W_IF,   16'd4);   // beq taken
      add(6'h04, 1, 1, 4'd1,  W_ID,   16'd5);
      add(6'h04, 1, 1, 4'd8,  W_BEQ_T,16'd5);
      add(6'h04, 0, 1, 4'd0,  W_IF,   16'd5);   // beq not taken
      add(6'h04, 0, 1, 4'd1,  W_ID,   16'd6);
      add(6'h04, 0, 1, 4'd8,  W_BEQ_N,16'd6);
      add(6'h02, 0, 1, 4'd0,  W_IF,   16'd6);   // j
      add(6'h02, 0, 1, 4'd1,  W_ID,   16'd7);
      add(6'h02, 0, 1, 4'd9,  W_JMP,  16'd7);
      add(6'h3F, 0, 0, 4'd0,  W_IF,   16'd7);   // hold with step=0
      add(6'h3F, 0, 0, 4'd0,  W_IF,   16'd7);
      add(6'h3F, 0, 1, 4'd0,  W_IF,   16'd7);   // illegal opcode
      add(6'h3F, 0, 1, 4'd1,  W_ID,   16'd8);
      add(6'h3F, 0, 1, 4'd15, W_HALT, 16'd8);
      add(6'h3F, 0, 1, 4'd15, W_HALT, 16'd8);

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         opcode = vecs[i].opcode; zero = vecs[i].zero; step = vecs[i].step;
         #1;
         check($sformatf("vec%0d_state", i), 16'(state), 16'(vecs[i].exp_state));
         check($sformatf("vec%0d_word", i), obs_word,
               gate(vecs[i].exp_word, vecs[i].step));
         check($sformatf("vec%0d_count", i), instr_count, vecs[i].exp_count);
         $display("vec %0d: op=%h step=%0d state=%0d word=%h count=%0d",
                  i, opcode, step, state, obs_word, instr_count);
      end

      // sw with step pulsing 1-in-4: each state holds 4 clks
      seq_sw[0] = 4'd0; seq_sw[1] = 4'd1; seq_sw[2] = 4'd2; seq_sw[3] = 4'd5;
      do_reset();
      opcode = 6'h2B;
      mw_cycles = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         step = ((c % 4) == 3);
         #1;
         check($sformatf("sw_div_c%0d_state", c), 16'(state), 16'(seq_sw[c / 4]));
         if (mem_write) mw_cycles++;
      end
      @(negedge clk);
      step = 1'b0;
      #1;
      check("sw_div_mem_write_cycles", 16'(mw_cycles), 16'd1);
      check("sw_div_back_to_if", 16'(state), 16'd0);
      $display("sw divided: mem_write cycles=%0d final state=%0d", mw_cycles, state);

      // Illegal opcode -> HALT, absorbing, then async reset out of it
      do_reset();
      opcode = 6'h3F;
      @(negedge clk); step = 1'b1;          // IF
      @(negedge clk);                       // ID
      @(negedge clk);                       // HALT
      #1;
      check("halt_state", 16'(state), 16'd15);
      check("halt_flag", 16'(halted), 16'd1);
      check("halt_count", instr_count, 16'd1);
      repeat (10) @(negedge clk);
      #1;
      check("halt_hold_state", 16'(state), 16'd15);
      check("halt_hold_count", instr_count, 16'd1);
      #1 rst_n = 1'b0;
      #1;
      check("halt_reset_state", 16'(state), 16'd0);
      check("halt_reset_flag", 16'(halted), 16'd0);
      check("halt_reset_count", instr_count, 16'd0);
      $display("halt: after reset state=%0d halted=%0d", state, halted);

      // Asynchronous reset mid-REX, observed before the next clk edge
      do_reset();
      opcode = 6'h00;
      @(negedge clk); step = 1'b1;          // IF
      @(negedge clk);                       // ID
      @(negedge clk);                       // REX
      #1;
      check("rex_state", 16'(state), 16'd6);
      step = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rex_async_state", 16'(state), 16'd0);
      check("rex_async_count", instr_count, 16'd0);
      $display("mid-REX reset: state=%0d count=%0d", state, instr_count);

      // 65535 jumps bring the count to 0xFFFF; the next IF step wraps it
      do_reset();
      opcode = 6'h02;
      @(negedge clk); step = 1'b1;
      repeat (3 * 65535) @(negedge clk);
      #1;
      check("wrap_pre_count", instr_count, 16'hFFFF);
      check("wrap_pre_state", 16'(state), 16'd0);
      @(negedge clk);
      #1;
      check("wrap_count", instr_count, 16'h0000);
      check("wrap_state", 16'(state), 16'd1);
      $display("wrap: count=%h state=%0d", instr_count, state);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
